// File: rtl/key_shift_pulse_gen_if.sv
// Button/pause inputs and move-pulse outputs of the horizontal-move front end.
// The master side drives the keys and pause; the slave side (the pulse generator) drives the pulses.
interface key_shift_pulse_gen_if;
   logic key_left;
   logic key_right;
   logic pause;
   logic left_shift;
   logic right_shift;
   logic key_active;

   modport master (
      output key_left, key_right, pause,
      input  left_shift, right_shift, key_active
   );

   modport slave (
      input  key_left, key_right, pause,
      output left_shift, right_shift, key_active
   );
endinterface

// File: rtl/key_shift_pulse_gen.sv
// Synchronises, debounces and gates the left/right buttons, then turns each accepted press into fixed-width move pulses.
// Define AUTO_REPEAT_EN to build the hold-to-repeat path (DELAY/REPEAT states and the repeat timer).
module key_shift_pulse_gen #(
   parameter int CLK_PER_MS      = 50000,
   parameter int DEBOUNCE_MS     = 20,
   parameter int REPEAT_DELAY_MS = 300,
   parameter int REPEAT_MS       = 100,
   parameter int PULSE_W         = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   key_shift_pulse_gen_if.slave bus
);
   localparam int PRE_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam int DB_W    = $clog2(DEBOUNCE_MS + 1);
   localparam int PW_W    = $clog2(PULSE_W + 1);
`ifdef AUTO_REPEAT_EN
   localparam int TMR_MAX = (REPEAT_DELAY_MS > REPEAT_MS) ? REPEAT_DELAY_MS : REPEAT_MS;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FIRE,
      ST_WAIT_REL
`ifdef AUTO_REPEAT_EN
      ,
      ST_DELAY,
      ST_REPEAT
`endif
   } state_t;

   logic [1:0]       key_raw;
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick;
   logic [1:0]       db_q;
   logic [1:0]       db_next;
   logic             both_db;
   logic             ka_q, ka_d;
   logic [1:0]       shift;

   assign key_raw = {bus.key_right, bus.key_left};

   always_comb begin
      sync1_d = key_raw;
      sync2_d = sync1_q;
      tick    = (pre_q == PRE_W'(CLK_PER_MS - 1));
      pre_d   = tick ? '0 : pre_q + 1'b1;
      both_db = db_next[0] & db_next[1];
      ka_d    = db_next[0] | db_next[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         pre_q   <= '0;
         ka_q    <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         pre_q   <= pre_d;
         ka_q    <= ka_d;
      end
   end

   // Index 0 is the left key, index 1 the right key.
   for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            db_d;
      state_t          state_q, state_d;
      logic [PW_W-1:0] pw_q, pw_d;
      logic            launch;
`ifdef AUTO_REPEAT_EN
      logic [TMR_W-1:0] timer_q, timer_d;
`endif

      always_comb begin
         cnt_d = cnt_q;
         db_d  = db_q[gi];
         if (sync2_q[gi] == db_q[gi]) begin
            cnt_d = '0;
         end else if (tick) begin
            if (cnt_q >= DB_W'(DEBOUNCE_MS - 1)) begin
               db_d  = sync2_q[gi];
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      assign db_next[gi] = db_d;

      // Release and blocking conditions override whatever the press is doing.
      always_comb begin
         state_d = state_q;
         launch  = 1'b0;
`ifdef AUTO_REPEAT_EN
         timer_d = timer_q;
`endif
         if (db_q[gi] && !db_d) begin
            state_d = ST_IDLE;
`ifdef AUTO_REPEAT_EN
            timer_d = '0;
`endif
         end else if (bus.pause || both_db) begin
            state_d = db_d ? ST_WAIT_REL : ST_IDLE;
`ifdef AUTO_REPEAT_EN
            timer_d = '0;
`endif
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (db_d && !db_q[gi]) state_d = ST_FIRE;
               end
               ST_FIRE: begin
                  launch = 1'b1;
`ifdef AUTO_REPEAT_EN
                  timer_d = TMR_W'(REPEAT_DELAY_MS);
                  state_d = ST_DELAY;
`else
                  state_d = ST_WAIT_REL;
`endif
               end
`ifdef AUTO_REPEAT_EN
               ST_DELAY, ST_REPEAT: begin
                  if (tick) begin
                     if (timer_q <= TMR_W'(1)) begin
                        launch  = 1'b1;
                        timer_d = TMR_W'(REPEAT_MS);
                        state_d = ST_REPEAT;
                     end else begin
                        timer_d = timer_q - 1'b1;
                     end
                  end
               end
`endif
               ST_WAIT_REL: begin
                  state_d = ST_WAIT_REL;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end

      // A launch that arrives while a pulse is still high is dropped.
      always_comb begin
         pw_d = pw_q;
         if (pw_q != '0) begin
            pw_d = pw_q - 1'b1;
         end else if (launch) begin
            pw_d = PW_W'(PULSE_W);
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q      <= '0;
            db_q[gi]   <= 1'b0;
            state_q    <= ST_IDLE;
            pw_q       <= '0;
`ifdef AUTO_REPEAT_EN
            timer_q    <= '0;
`endif
         end else begin
            cnt_q      <= cnt_d;
            db_q[gi]   <= db_d;
            state_q    <= state_d;
            pw_q       <= pw_d;
`ifdef AUTO_REPEAT_EN
            timer_q    <= timer_d;
`endif
         end
      end

      assign shift[gi] = (pw_q != '0);
   end

   assign bus.left_shift  = shift[0];
   assign bus.right_shift = shift[1];
   assign bus.key_active  = ka_q;
endmodule
